ahb_apb_bridge_param: RTL

- Parametrised AHB-Lite slave to APB master bridge, second generation of the team's bridge.
- Generalised in data width, APB address width and peripheral count.
- Adds HTRANS qualification, APB3 wait states (PREADY), error signalling (PSLVERR to two-cycle HRESP), an APB timeout and back-to-back transfer acceptance.
- Sits between the AHB interconnect and the APB peripheral group; drives one-hot PSEL per peripheral.

---
 rtl/ahb_apb_pkg.sv | 21 ++
 rtl/apb_sel_decoder.sv | 18 +
 rtl/ahb_apb_bridge_param.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and AHB encodings for the parametrised AHB-Lite to APB bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StErr,
    StDone
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_sel_decoder.sv
// Binary peripheral index to one-hot PSEL decoder with an enable; all-zero when disabled.
module apb_sel_decoder #(
  parameter  int unsigned SEL_W   = 2,
  localparam int unsigned NUM_SLV = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_SLV-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite slave to APB3 master bridge with wait states, PSLVERR/timeout error response and
// back-to-back acceptance. Define WRITE_POST_EN to post writes behind a one-entry pending slot.
module ahb_apb_bridge_param
  import ahb_apb_pkg::*;
#(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned PADDR_W = 5,
  parameter  int unsigned SEL_W   = 2,
  parameter  int unsigned TIMEOUT = 16,
  localparam int unsigned NUM_SLV = 2 ** SEL_W,
  localparam int unsigned ADDR_W  = SEL_W + PADDR_W
) (
  input  logic               HCLK,
  input  logic               RESET,
  input  logic               HSEL,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic               HREADY,
  input  logic [DATA_W-1:0]  HWDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [DATA_W-1:0]  HRDATA,
  output logic [NUM_SLV-1:0] PSEL,
  output logic [PADDR_W-1:0] PADDR,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [DATA_W-1:0]  PWDATA,
  input  logic [DATA_W-1:0]  PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

`ifdef WRITE_POST_EN
  localparam bit POST_EN = 1'b1;
`else
  localparam bit POST_EN = 1'b0;
`endif

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TCNT_MAX = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               write_q, write_d;
  logic               posted_q, posted_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic               pend_write_q, pend_write_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;

  logic               hreadyout_q, hreadyout_d;
  logic               hresp_q, hresp_d;
  logic [DATA_W-1:0]  hrdata_q, hrdata_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;

  logic               accept;
  logic               timeout_hit;
  logic               in_flight;
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic               start_write;
  logic               psel_en;

  assign accept      = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_MAX);
  assign in_flight   = posted_q && (state_q inside {StWdata, StSetup, StAccess});

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    posted_d     = posted_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_write_d = pend_write_q;
    tcnt_d       = tcnt_q;
    hreadyout_d  = hreadyout_q;
    hresp_d      = hresp_q;
    hrdata_d     = hrdata_q;
    paddr_d      = paddr_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    start        = 1'b0;
    start_addr   = HADDR;
    start_write  = HWRITE;

    unique case (state_q)
      StIdle, StDone: begin
        if (POST_EN && pend_q) begin
          start       = 1'b1;
          start_addr  = pend_addr_q;
          start_write = pend_write_q;
          pend_d      = 1'b0;
        end else if (accept) begin
          start = 1'b1;
        end else begin
          state_d     = StIdle;
          hreadyout_d = 1'b1;
          hresp_d     = HRESP_OKAY;
        end
      end
      StWdata: begin
        pwdata_d = HWDATA;
        state_d  = StSetup;
        paddr_d  = addr_q[PADDR_W-1:0];
        pwrite_d = write_q;
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        tcnt_d    = '0;
      end
      StAccess: begin
        if (PREADY || timeout_hit) begin
          penable_d = 1'b0;
          // Posted writes have already completed on AHB, so their errors are swallowed.
          if ((PSLVERR || !PREADY) && !posted_q) begin
            state_d     = StErr;
            hresp_d     = HRESP_ERROR;
            hreadyout_d = 1'b0;
          end else begin
            state_d     = StDone;
            hresp_d     = HRESP_OKAY;
            hreadyout_d = !(posted_q && pend_q);
            if (!write_q) begin
              hrdata_d = PRDATA;
            end
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StErr: begin
        state_d     = StDone;
        hreadyout_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start) begin
      addr_d  = start_addr;
      write_d = start_write;
      hresp_d = HRESP_OKAY;
      if (start_write) begin
        state_d     = StWdata;
        posted_d    = POST_EN;
        hreadyout_d = POST_EN;
      end else begin
        state_d     = StSetup;
        posted_d    = 1'b0;
        hreadyout_d = 1'b0;
        paddr_d     = start_addr[PADDR_W-1:0];
        pwrite_d    = 1'b0;
      end
    end

    // A transfer arriving behind a posted write parks here and stalls its data phase.
    if (POST_EN && in_flight && !pend_q && accept) begin
      pend_d       = 1'b1;
      pend_addr_d  = HADDR;
      pend_write_d = HWRITE;
      hreadyout_d  = 1'b0;
    end
  end

  assign psel_en = (state_d == StSetup) || (state_d == StAccess);

  apb_sel_decoder #(
    .SEL_W (SEL_W)
  ) u_sel_decoder (
    .sel    (addr_d[ADDR_W-1 -: SEL_W]),
    .en     (psel_en),
    .onehot (psel_d)
  );

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      write_q      <= 1'b0;
      posted_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_write_q <= 1'b0;
      tcnt_q       <= '0;
      hreadyout_q  <= 1'b1;
      hresp_q      <= HRESP_OKAY;
      hrdata_q     <= '0;
      psel_q       <= '0;
      paddr_q      <= '0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      posted_q     <= posted_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_write_q <= pend_write_d;
      tcnt_q       <= tcnt_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      hrdata_q     <= hrdata_d;
      psel_q       <= psel_d;
      paddr_q      <= paddr_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
